// File: rtl/alu_result_stage_pkg.sv
// Shared definitions for the ALU result-capture stage: widths, the stored
// result entry and the opcode tags also used by the ALU and control unit.
package alu_result_stage_pkg;

  localparam int DATA_W = 32;
  localparam int OP_W   = 5;

  typedef struct packed {
    logic [DATA_W-1:0] hi;
    logic [DATA_W-1:0] lo;
    logic [OP_W-1:0]   op;
  } result_entry_t;

  // Opcode tags carried alongside each result.
  localparam logic [OP_W-1:0] OP_AND = 5'h00;
  localparam logic [OP_W-1:0] OP_OR  = 5'h01;
  localparam logic [OP_W-1:0] OP_XOR = 5'h02;
  localparam logic [OP_W-1:0] OP_NOT = 5'h03;
  localparam logic [OP_W-1:0] OP_ADD = 5'h04;
  localparam logic [OP_W-1:0] OP_SUB = 5'h05;
  localparam logic [OP_W-1:0] OP_SHL = 5'h06;
  localparam logic [OP_W-1:0] OP_SHR = 5'h07;
  localparam logic [OP_W-1:0] OP_MUL = 5'h08;
  localparam logic [OP_W-1:0] OP_DIV = 5'h09;

endpackage

// File: rtl/alu_result_stage_fifo_ctrl.sv
// Pointer/count bookkeeping for the result FIFO. Full and empty come from the
// occupancy count only, so pointer equality is never ambiguous.
module sync_fifo_ctrl #(
  parameter int DEPTH = 2,
  parameter int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             push_req,
  input  logic             pop_req,
  output logic [PTR_W-1:0] wr_ptr,
  output logic [PTR_W-1:0] rd_ptr,
  output logic [CNT_W-1:0] count,
  output logic             in_ready,
  output logic             empty,
  output logic             push_ok,
  output logic             pop_ok,
  output logic             pop_err
);

  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [PTR_W-1:0] LAST_C  = PTR_W'(DEPTH - 1);

  logic [CNT_W-1:0] count_next;

  assign empty   = (count == '0);
  assign push_ok = push_req && in_ready;
  assign pop_ok  = pop_req && !empty;
  assign pop_err = pop_req && empty;

  // NOTE: every variable written in an always_comb gets a default first, so
  // no path through the block can leave it unassigned and infer a latch.
  always_comb begin
    count_next = count;
    if (push_ok && !pop_ok) begin
      count_next = count + 1'b1;
    end else if (pop_ok && !push_ok) begin
      count_next = count - 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clock) begin
    if (clear) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      in_ready <= 1'b1;
    end else begin
      if (push_ok) begin
        wr_ptr <= (wr_ptr == LAST_C) ? '0 : wr_ptr + 1'b1;
      end
      if (pop_ok) begin
        rd_ptr <= (rd_ptr == LAST_C) ? '0 : rd_ptr + 1'b1;
      end
      count    <= count_next;
      // Registered from the next count: a popped full FIFO reopens one cycle later.
      in_ready <= (count_next != DEPTH_C);
    end
  end

endmodule

// File: rtl/alu_result_stage.sv
// Result-capture stage behind the ALU function units: a small FIFO of 64-bit
// results with flags, and a hi/lo gate onto the 32-bit datapath bus.
module alu_result_stage
  import alu_result_stage_pkg::*;
#(
  parameter int DATA_W = alu_result_stage_pkg::DATA_W,
  parameter int DEPTH  = 2,
  parameter int OP_W   = alu_result_stage_pkg::OP_W
) (
  input  logic              clock,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_hi,
  input  logic [DATA_W-1:0] in_lo,
  input  logic [OP_W-1:0]   in_op,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_hi,
  output logic [DATA_W-1:0] out_lo,
  output logic [OP_W-1:0]   out_op,
  output logic              out_zero,
  output logic              out_neg,
  input  logic              pop,
  input  logic              zhi_out,
  input  logic              zlo_out,
  output logic [DATA_W-1:0] bus_out,
  output logic              err
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             empty;
  logic             push_ok;
  logic             pop_ok;
  logic             pop_err;
  result_entry_t    mem [DEPTH];
  result_entry_t    head;

  sync_fifo_ctrl #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W),
    .CNT_W (CNT_W)
  ) u_ctrl (
    .clock    (clock),
    .clear    (clear),
    .push_req (in_valid),
    .pop_req  (pop),
    .wr_ptr   (wr_ptr),
    .rd_ptr   (rd_ptr),
    .count    (count),
    .in_ready (in_ready),
    .empty    (empty),
    .push_ok  (push_ok),
    .pop_ok   (pop_ok),
    .pop_err  (pop_err)
  );

  // NOTE: storage is deliberately not reset; an entry is only visible while
  // count covers it, so stale contents after clear can never be observed.
  always_ff @(posedge clock) begin
    if (push_ok && !clear) begin
      mem[wr_ptr] <= '{hi: in_hi, lo: in_lo, op: in_op};
    end
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      err <= 1'b0;
    end else if (pop_err || (zhi_out && zlo_out)) begin
      err <= 1'b1;
    end
  end

  assign head      = mem[rd_ptr];
  assign out_valid = !empty;

  // Head fields read as zero when empty so downstream branch logic sees clean flags.
  always_comb begin
    out_hi   = '0;
    out_lo   = '0;
    out_op   = '0;
    out_zero = 1'b0;
    out_neg  = 1'b0;
    if (out_valid) begin
      out_hi   = head.hi;
      out_lo   = head.lo;
      out_op   = head.op;
      out_zero = (head.lo == '0);
      out_neg  = head.lo[DATA_W-1];
    end
  end

  // hi takes precedence when both gates are raised; the conflict is flagged in err.
  always_comb begin
    bus_out = '0;
    if (out_valid) begin
      if (zhi_out) begin
        bus_out = out_hi;
      end else if (zlo_out) begin
        bus_out = out_lo;
      end
    end
  end

  // Tie off the count in this scope; occupancy decisions live in the controller.
  logic unused_count;
  assign unused_count = ^count;

endmodule
